sprite_draw_pipe: RTL and testbench

- Downstream consumer of the 30x30, 24-bit RGB sprite ROM.
- Takes the VGA controller's DrawX/DrawY stream and generates the ROM address. Registers the returned texel, keys out the near-white background and emits sprite colour plus a coverage flag to the colour mapper.
- Latches the on-screen position once per frame. Runs a hit-flash state machine so the sprite blinks after a hit event.

---
 rtl/sprite_pkg.sv | 30 +++
 rtl/sprite_flash_fsm.sv | 70 +++++++
 rtl/sprite_draw_pipe.sv | 84 ++++++++
 tb/tb_sprite_draw_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite draw pipeline.
// Defining SPRITE_SCALE2X_EN doubles the sprite footprint on screen.
package sprite_pkg;

  typedef logic [23:0] rgb24_t;

  typedef enum logic {
    VISIBLE = 1'b0,
    FLASH   = 1'b1
  } flash_state_t;

  localparam int SPR_W_C        = 30;
  localparam int SPR_H_C        = 30;
  localparam int SPR_DEPTH_C    = SPR_W_C * SPR_H_C;
  localparam logic [7:0] KEY_MIN_C = 8'hF0;
  localparam int FLASH_FRAMES_C = 16;
  localparam int BLINK_DIV_C    = 2;

`ifdef SPRITE_SCALE2X_EN
  localparam int SCALE_SH_C = 1;
`else
  localparam int SCALE_SH_C = 0;
`endif

  // Near-white texels are the sprite sheet's background colour.
  function automatic logic is_keyed(input rgb24_t texel, input logic [7:0] key_min);
    return (texel[23:16] >= key_min) && (texel[15:8] >= key_min) && (texel[7:0] >= key_min);
  endfunction

endpackage

// File: rtl/sprite_flash_fsm.sv
// Hit-flash sequencer: after a hit the sprite blinks for a fixed number of frames.
module sprite_flash_fsm
  import sprite_pkg::*;
#(
  parameter int FLASH_FRAMES = FLASH_FRAMES_C,
  parameter int BLINK_DIV    = BLINK_DIV_C
) (
  input  logic clk,
  input  logic reset_n,
  input  logic frame_start,
  input  logic hit,
  output logic vis,
  output logic flashing
);

  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  flash_state_t  state;
  logic [FW-1:0] fcnt;
  logic [BW-1:0] bcnt;

  // A hit always restarts the sequence and suppresses that cycle's frame tick.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= VISIBLE;
      fcnt     <= '0;
      bcnt     <= '0;
      vis      <= 1'b1;
      flashing <= 1'b0;
    end else if (hit) begin
      state    <= FLASH;
      fcnt     <= FW'(FLASH_FRAMES - 1);
      bcnt     <= BW'(BLINK_DIV - 1);
      vis      <= 1'b0;
      flashing <= 1'b1;
    end else begin
      case (state)
        VISIBLE: begin
          vis      <= 1'b1;
          flashing <= 1'b0;
        end
        FLASH: begin
          if (frame_start) begin
            if (bcnt == '0) begin
              vis  <= ~vis;
              bcnt <= BW'(BLINK_DIV - 1);
            end else begin
              bcnt <= bcnt - 1'b1;
            end
            if (fcnt == '0) begin
              state    <= VISIBLE;
              vis      <= 1'b1;
              flashing <= 1'b0;
              bcnt     <= '0;
            end else begin
              fcnt <= fcnt - 1'b1;
            end
          end
        end
        default: begin
          state    <= VISIBLE;
          vis      <= 1'b1;
          flashing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sprite_draw_pipe.sv
// Sprite address/keying pipeline: DrawX/DrawY in, keyed sprite colour out two cycles later.
// Optional build macro SPRITE_SCALE2X_EN draws every texel as a 2x2 block.
module sprite_draw_pipe
  import sprite_pkg::*;
#(
  parameter int         SPR_W        = SPR_W_C,
  parameter int         SPR_H        = SPR_H_C,
  parameter logic [7:0] KEY_MIN      = KEY_MIN_C,
  parameter int         FLASH_FRAMES = FLASH_FRAMES_C,
  parameter int         BLINK_DIV    = BLINK_DIV_C
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_start,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        hit,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [9:0]  rom_addr,
  input  logic [23:0] rom_data,
  output logic        sprite_on,
  output rgb24_t      sprite_rgb,
  output logic        flashing
);

  logic [9:0]  lat_x, lat_y;
  logic [10:0] draw_x_w, draw_y_w, lat_x_w, lat_y_w;
  logic [10:0] box_w, box_h, dx, dy;
  logic [9:0]  off_x, off_y, addr_next;
  logic        in_box, in_box_q, opaque, on_next, vis;

  // Bounds are 11 bits wide so a sprite hanging off the right/bottom never wraps to column/row 0.
  always_comb begin
    draw_x_w  = {1'b0, DrawX};
    draw_y_w  = {1'b0, DrawY};
    lat_x_w   = {1'b0, lat_x};
    lat_y_w   = {1'b0, lat_y};
    box_w     = 11'(SPR_W << SCALE_SH_C);
    box_h     = 11'(SPR_H << SCALE_SH_C);
    dx        = draw_x_w - lat_x_w;
    dy        = draw_y_w - lat_y_w;
    in_box    = (draw_x_w >= lat_x_w) && (draw_x_w < lat_x_w + box_w) &&
                (draw_y_w >= lat_y_w) && (draw_y_w < lat_y_w + box_h);
    off_x     = 10'(dx >> SCALE_SH_C);
    off_y     = 10'(dy >> SCALE_SH_C);
    addr_next = off_y * 10'(SPR_W) + off_x;
    opaque    = !is_keyed(rom_data, KEY_MIN);
    on_next   = in_box_q && opaque && vis;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      lat_x      <= '0;
      lat_y      <= '0;
      rom_addr   <= '0;
      in_box_q   <= 1'b0;
      sprite_on  <= 1'b0;
      sprite_rgb <= '0;
    end else begin
      if (frame_start) begin
        lat_x <= pos_x;
        lat_y <= pos_y;
      end
      rom_addr   <= in_box ? addr_next : '0;
      in_box_q   <= in_box;
      sprite_on  <= on_next;
      sprite_rgb <= on_next ? rgb24_t'(rom_data) : '0;
    end
  end

  sprite_flash_fsm #(
    .FLASH_FRAMES(FLASH_FRAMES),
    .BLINK_DIV   (BLINK_DIV)
  ) u_flash (
    .clk        (Clk),
    .reset_n    (Reset_n),
    .frame_start(frame_start),
    .hit        (hit),
    .vis        (vis),
    .flashing   (flashing)
  );

endmodule

// File: tb/tb_sprite_draw_pipe.sv
// Directed bench for sprite_draw_pipe with a combinational ROM model.
// The ROM returns {14'h0, addr} (always opaque) unless a forced texel is selected.
module tb_sprite_draw_pipe;

`ifdef SPRITE_SCALE2X_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif

  logic        Clk;
  logic        Reset_n;
  logic        frame_start;
  logic [9:0]  pos_x, pos_y;
  logic        hit;
  logic [9:0]  DrawX, DrawY;
  logic [9:0]  rom_addr;
  logic [23:0] rom_data;
  logic        sprite_on;
  logic [23:0] sprite_rgb;
  logic        flashing;

  logic        force_en;
  logic [23:0] force_texel;
  int          model_lx, model_ly;
  int          checks, failures;

  sprite_draw_pipe dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_start(frame_start),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .hit        (hit),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .sprite_on  (sprite_on),
    .sprite_rgb (sprite_rgb),
    .flashing   (flashing)
  );

  always_comb rom_data = force_en ? force_texel : {14'h0, rom_addr};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic exp_in(input int x, input int y, input int lx, input int ly);
    return (x >= lx) && (x < lx + SC * 30) && (y >= ly) && (y < ly + SC * 30);
  endfunction

  function automatic int exp_addr(input int x, input int y, input int lx, input int ly);
    return exp_in(x, y, lx, ly) ? ((y - ly) / SC) * 30 + (x - lx) / SC : 0;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pulseFrame();
    frame_start = 1'b1;
    model_lx = int'(pos_x);
    model_ly = int'(pos_y);
    step();
    frame_start = 1'b0;
  endtask

  task automatic pulseHit();
    hit = 1'b1;
    step();
    hit = 1'b0;
  endtask

  // Hold a coordinate for two edges: address after the first, colour after the second.
  task automatic checkPixel(input string tag, input int x, input int y, input logic v);
    int  a;
    logic on_e;
    a    = exp_addr(x, y, model_lx, model_ly);
    on_e = exp_in(x, y, model_lx, model_ly) && v;
    applyStimulus(x, y);
    checkOutput({tag, ".addr"}, 32'(rom_addr), 32'(a));
    step();
    checkOutput({tag, ".on"}, 32'(sprite_on), 32'(on_e));
    checkOutput({tag, ".rgb"}, 32'(sprite_rgb), on_e ? 32'(a) : 32'd0);
  endtask

  initial begin
    int prev;
    checks = 0;
    failures = 0;
    Reset_n = 1'b0;
    frame_start = 1'b0;
    hit = 1'b0;
    pos_x = '0;
    pos_y = '0;
    DrawX = '0;
    DrawY = '0;
    force_en = 1'b0;
    force_texel = '0;
    model_lx = 0;
    model_ly = 0;
    step();
    step();
    checkOutput("reset.addr", 32'(rom_addr), 32'd0);
    checkOutput("reset.on", 32'(sprite_on), 32'd0);
    checkOutput("reset.rgb", 32'(sprite_rgb), 32'd0);
    checkOutput("reset.flashing", 32'(flashing), 32'd0);
    Reset_n = 1'b1;
    checkPixel("reset.origin", 5, 1, 1'b1);

    $display("[TB] address and keying");
    pos_x = 10'd100;
    pos_y = 10'd50;
    pulseFrame();
    checkPixel("addr.first", 100, 50, 1'b1);
    checkPixel("addr.last", 129, 79, 1'b1);
    checkPixel("addr.rightout", 130 + (SC - 1) * 30, 79, 1'b1);
    checkPixel("addr.col130", 130, 50, 1'b1);

    force_en = 1'b1;
    force_texel = 24'hFFFCFD;
    applyStimulus(101, 50);
    applyStimulus(0, 0);
    checkOutput("key.white.on", 32'(sprite_on), 32'd0);
    checkOutput("key.white.rgb", 32'(sprite_rgb), 32'd0);
    force_texel = 24'h32CCCC;
    applyStimulus(102, 50);
    checkOutput("key.lat1.on", 32'(sprite_on), 32'd0);
    applyStimulus(0, 0);
    checkOutput("key.lat2.on", 32'(sprite_on), 32'd1);
    checkOutput("key.lat2.rgb", 32'(sprite_rgb), 32'h32CCCC);
    step();
    checkOutput("key.lat3.on", 32'(sprite_on), 32'd0);
    force_texel = 24'hF0F0F0;
    applyStimulus(103, 50);
    step();
    checkOutput("key.min.on", 32'(sprite_on), 32'd0);
    force_texel = 24'hF0EFF0;
    applyStimulus(103, 50);
    step();
    checkOutput("key.below.on", 32'(sprite_on), 32'd1);
    checkOutput("key.below.rgb", 32'(sprite_rgb), 32'hF0EFF0);
    force_en = 1'b0;

    $display("[TB] edge clip");
    pos_x = 10'd625;
    pos_y = 10'd465;
    pulseFrame();
    prev = -1;
    for (int x = 620; x < 640; x++) begin
      applyStimulus(x, 470);
      checkOutput($sformatf("clip.addr x=%0d", x), 32'(rom_addr), 32'(exp_addr(x, 470, model_lx, model_ly)));
      if (prev >= 0) begin
        checkOutput($sformatf("clip.on x=%0d", prev), 32'(sprite_on), 32'(exp_in(prev, 470, model_lx, model_ly)));
        checkOutput($sformatf("clip.rgb x=%0d", prev), 32'(sprite_rgb), 32'(exp_addr(prev, 470, model_lx, model_ly)));
      end
      prev = x;
    end
    checkPixel("clip.col0", 0, 470, 1'b1);
    checkPixel("clip.row0", 630, 0, 1'b1);
    pos_x = 10'd1000;
    pos_y = 10'd0;
    pulseFrame();
    checkPixel("clip.nowrap", 1020, 0, 1'b1);

    $display("[TB] position latch");
    pos_x = 10'd100;
    pos_y = 10'd50;
    pulseFrame();
    pos_x = 10'd200;
    checkPixel("latch.old.in", 100, 50, 1'b1);
    checkPixel("latch.new.out", 200, 50, 1'b1);
    pulseFrame();
    checkPixel("latch.new.in", 200, 50, 1'b1);
    checkPixel("latch.old.out", 100, 50, 1'b1);

    $display("[TB] flash");
    pulseHit();
    checkOutput("flash.start", 32'(flashing), 32'd1);
    checkPixel("flash.hidden", 205, 55, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      pulseFrame();
      checkOutput($sformatf("flash.a%0d.flashing", k), 32'(flashing), 32'd1);
      checkPixel($sformatf("flash.a%0d", k), 205, 55, 1'(k >> 1));
    end
    pulseHit();
    checkPixel("flash.rehit", 205, 55, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      pulseFrame();
      checkOutput($sformatf("flash.b%0d.flashing", k), 32'(flashing), 32'd1);
      checkPixel($sformatf("flash.b%0d", k), 205, 55, 1'(k >> 1));
    end
    pulseFrame();
    checkOutput("flash.end.flashing", 32'(flashing), 32'd0);
    checkPixel("flash.end", 205, 55, 1'b1);

    hit = 1'b1;
    frame_start = 1'b1;
    step();
    hit = 1'b0;
    frame_start = 1'b0;
    checkOutput("both.flashing", 32'(flashing), 32'd1);
    for (int k = 1; k <= 15; k++) begin
      pulseFrame();
      checkOutput($sformatf("both.c%0d.flashing", k), 32'(flashing), 32'd1);
      if (k <= 2) checkPixel($sformatf("both.c%0d", k), 205, 55, 1'(k >> 1));
    end
    pulseFrame();
    checkOutput("both.end.flashing", 32'(flashing), 32'd0);

    $display("[TB] reset during flash");
    pulseHit();
    pulseFrame();
    applyStimulus(205, 55);
    step();
    Reset_n = 1'b0;
    step();
    checkOutput("rst.addr", 32'(rom_addr), 32'd0);
    checkOutput("rst.on", 32'(sprite_on), 32'd0);
    checkOutput("rst.rgb", 32'(sprite_rgb), 32'd0);
    checkOutput("rst.flashing", 32'(flashing), 32'd0);
    Reset_n = 1'b1;
    model_lx = 0;
    model_ly = 0;
    checkPixel("rst.origin", 5, 1, 1'b1);
    checkPixel("rst.oldpos", 205, 55, 1'b1);

`ifdef SPRITE_SCALE2X_EN
    $display("[TB] scale2x");
    pos_x = 10'd100;
    pos_y = 10'd50;
    pulseFrame();
    applyStimulus(159, 50);
    checkOutput("scale.dx59", 32'(rom_addr), 32'd29);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
